// File: rtl/pattern_gen_multi.sv
// Multi-lane pattern generator: CHANNELS independent lanes, each with its own
// mode (hold / up-count / LFSR / walking-one) and prescaler, set up over a valid/ready port.

module pattern_gen_lane #(
    parameter int              WIDTH = 8,
    parameter int              DIV_W = 8,
    parameter logic [WIDTH-1:0] TAPS = 8'hB8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             load,
    input  logic [1:0]       cfg_mode,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic [WIDTH-1:0] cfg_seed,
    output logic [WIDTH-1:0] pat,
    output logic             tick
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic [DIV_W-1:0] div_q, div_d, pc_q, pc_d;
    logic [WIDTH-1:0] pat_q, pat_d, step_val, seed_fix;
    logic             tick_q, tick_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= '0;
            div_q   <= '0;
            pc_q    <= '0;
            pat_q   <= '0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            div_q   <= div_d;
            pc_q    <= pc_d;
            pat_q   <= pat_d;
            tick_q  <= tick_d;
        end
    end

    // LFSR and walking-one would be stuck/empty on a zero seed, so force a 1.
    assign seed_fix = (cfg_mode[1] && cfg_seed == '0) ? WIDTH'(1) : cfg_seed;

    always_comb begin
        step_val = pat_q;
        unique case (mode_q)
            2'd1:    step_val = pat_q + WIDTH'(1);
            2'd2:    step_val = (pat_q >> 1) ^ (pat_q[0] ? TAPS : '0);
            2'd3:    step_val = {pat_q[WIDTH-2:0], pat_q[WIDTH-1]};
            default: step_val = pat_q;
        endcase
    end

    // A load takes priority over a step that falls due in the same cycle.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        div_d   = div_q;
        pc_d    = pc_q;
        pat_d   = pat_q;
        tick_d  = 1'b0;
        if (load) begin
            state_d = RUN;
            mode_d  = cfg_mode;
            div_d   = cfg_div;
            pc_d    = '0;
            pat_d   = seed_fix;
        end else if (state_q == RUN && enable) begin
            if (pc_q == div_q) begin
                pc_d   = '0;
                pat_d  = step_val;
                tick_d = 1'b1;
            end else begin
                pc_d = pc_q + DIV_W'(1);
            end
        end
    end

    assign pat  = pat_q;
    assign tick = tick_q;
endmodule

module pattern_gen_multi #(
    parameter int               WIDTH    = 8,
    parameter int               CHANNELS = 2,
    parameter int               DIV_W    = 8,
    parameter logic [WIDTH-1:0] TAPS     = 8'hB8,
    localparam int              CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic [CH_W-1:0]           cfg_ch,
    input  logic [1:0]                cfg_mode,
    input  logic [DIV_W-1:0]          cfg_div,
    input  logic [WIDTH-1:0]          cfg_seed,
    output logic [CHANNELS*WIDTH-1:0] pat_out,
    output logic [CHANNELS-1:0]       tick
);
    logic                               ready_q;
    logic                               accept;
    logic [CHANNELS-1:0]                load;
    logic [CHANNELS-1:0][WIDTH-1:0]     pat_lane;

    assign accept = cfg_valid & ready_q;

    // One busy cycle after every accepted transfer.
    always_ff @(posedge clk) begin
        if (rst) ready_q <= 1'b0;
        else     ready_q <= ~accept;
    end

    // An out-of-range cfg_ch matches no lane, so the transfer is simply dropped.
    for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
        assign load[k] = accept && (cfg_ch == CH_W'(k));

        pattern_gen_lane #(
            .WIDTH (WIDTH),
            .DIV_W (DIV_W),
            .TAPS  (TAPS)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .enable   (enable),
            .load     (load[k]),
            .cfg_mode (cfg_mode),
            .cfg_div  (cfg_div),
            .cfg_seed (cfg_seed),
            .pat      (pat_lane[k]),
            .tick     (tick[k])
        );
    end

    assign pat_out   = pat_lane;
    assign cfg_ready = ready_q;
endmodule

// File: tb/tb_pattern_gen_multi.sv
// Bench for pattern_gen_multi: directed scenarios plus random traffic, all
// checked against a model that derives each lane's pattern from its enabled-cycle count.

module tb_pattern_gen_multi;
    localparam int W  = 8;
    localparam int CH = 3;   // three lanes so that cfg_ch = 3 is a genuine out-of-range target
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            rst, enable, cfg_valid, cfg_ready;
    logic [1:0]      cfg_ch;
    logic [1:0]      cfg_mode;
    logic [DW-1:0]   cfg_div;
    logic [W-1:0]    cfg_seed;
    logic [CH*W-1:0] pat_out;
    logic [CH-1:0]   tick;

    int errors = 0;
    int checks = 0;
    int acc_obs = 0;

    int m_run[CH], m_mode[CH], m_div[CH], m_seed[CH], m_cnt[CH];
    bit m_tick[CH];
    bit m_ready;

    pattern_gen_multi #(.WIDTH(W), .CHANNELS(CH), .DIV_W(DW), .TAPS(8'hB8)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
        .cfg_mode(cfg_mode), .cfg_div(cfg_div), .cfg_seed(cfg_seed),
        .pat_out(pat_out), .tick(tick)
    );

    always #5 clk = ~clk;

    // Pattern after n steps from seed, from the mode definitions directly.
    function automatic int ref_pat(int mode, int seed, int n);
        int p = seed;
        case (mode)
            1: p = (seed + n) % 256;
            2: repeat (n) p = (p >> 1) ^ (((p & 1) != 0) ? 'hB8 : 0);
            3: begin
                int r = n % 8;
                p = ((seed << r) | (seed >> (8 - r))) & 'hFF;
            end
            default: p = seed;
        endcase
        return p;
    endfunction

    function automatic logic [CH*W-1:0] exp_pat();
        logic [CH*W-1:0] v = '0;
        for (int k = 0; k < CH; k++)
            v[k*W +: W] = W'(ref_pat(m_mode[k], m_seed[k], m_cnt[k] / (m_div[k] + 1)));
        return v;
    endfunction

    function automatic logic [CH-1:0] exp_tick();
        logic [CH-1:0] v = '0;
        for (int k = 0; k < CH; k++) v[k] = m_tick[k];
        return v;
    endfunction

    task automatic model_edge();
        bit acc;
        if (rst) begin
            m_ready = 0;
            for (int k = 0; k < CH; k++) begin
                m_run[k] = 0; m_mode[k] = 0; m_div[k] = 0;
                m_seed[k] = 0; m_cnt[k] = 0; m_tick[k] = 0;
            end
            return;
        end
        acc = cfg_valid && m_ready;
        for (int k = 0; k < CH; k++) begin
            if (acc && int'(cfg_ch) == k) begin
                m_run[k]  = 1;
                m_mode[k] = int'(cfg_mode);
                m_div[k]  = int'(cfg_div);
                m_seed[k] = (cfg_mode >= 2 && cfg_seed == 0) ? 1 : int'(cfg_seed);
                m_cnt[k]  = 0;
                m_tick[k] = 0;
            end else if (m_run[k] != 0 && enable) begin
                m_cnt[k]++;
                m_tick[k] = (m_cnt[k] % (m_div[k] + 1)) == 0;
            end else begin
                m_tick[k] = 0;
            end
        end
        m_ready = !acc;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        if (cfg_valid && cfg_ready) acc_obs++;
        @(posedge clk);
        model_edge();
        #1;
        chk("model_pat",   32'(pat_out),   32'(exp_pat()));
        chk("model_tick",  32'(tick),      32'(exp_tick()));
        chk("model_ready", 32'(cfg_ready), 32'(m_ready));
    endtask

    task automatic cfg(input int ch, input int mode, input int div, input int seed);
        cfg_valid = 1'b1;
        cfg_ch    = 2'(ch);
        cfg_mode  = 2'(mode);
        cfg_div   = DW'(div);
        cfg_seed  = W'(seed);
        step();
        cfg_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; cfg_valid = 1'b0;
        cfg_ch = '0; cfg_mode = '0; cfg_div = '0; cfg_seed = '0;

        // reset and idle
        step(); step();
        chk("rst_pat", 32'(pat_out), 0);
        chk("rst_tick", 32'(tick), 0);
        chk("rst_ready", 32'(cfg_ready), 0);
        rst = 1'b0;
        step();
        chk("ready_after_rst", 32'(cfg_ready), 1);
        enable = 1'b1;
        step(); step();
        chk("idle_pat", 32'(pat_out), 0);

        // up-count, div 2
        cfg(0, 1, 2, 'hFE);
        chk("up_seed", 32'(pat_out[7:0]), 'hFE);
        for (int n = 0; n < 2; n++) begin
            step(); step();
            chk("up_gap_tick", 32'(tick[0]), 0);
            step();
            chk("up_val", 32'(pat_out[7:0]), (n == 0) ? 'hFF : 'h00);
            chk("up_tick", 32'(tick[0]), 1);
        end

        // LFSR with zero seed on lane 1
        cfg(1, 2, 0, 'h00);
        chk("lfsr_seed", 32'(pat_out[15:8]), 'h01);
        step(); chk("lfsr_1", 32'(pat_out[15:8]), 'hB8);
        step(); chk("lfsr_2", 32'(pat_out[15:8]), 'h5C);
        step(); chk("lfsr_3", 32'(pat_out[15:8]), 'h2E);

        // walking-one wrap and enable freeze
        cfg(0, 3, 0, 'h80);
        step();
        chk("walk_wrap", 32'(pat_out[7:0]), 'h01);
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("frz_pat", 32'(pat_out[7:0]), 'h01);
            chk("frz_tick", 32'(tick), 0);
        end
        enable = 1'b1;
        step();
        chk("walk_resume", 32'(pat_out[7:0]), 'h02);

        // cfg_valid held for 4 cycles
        acc_obs   = 0;
        cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_mode = 2'd1; cfg_div = 8'd5; cfg_seed = 8'h10;
        for (int i = 0; i < 4; i++) begin
            chk("hold_ready", 32'(cfg_ready), (i % 2 == 0) ? 1 : 0);
            step();
        end
        cfg_valid = 1'b0;
        chk("hold_accepts", 32'(acc_obs), 2);
        step();

        // out-of-range lane: only the busy cycle is visible
        enable = 1'b0;
        cfg(3, 1, 0, 'hAA);
        chk("oor_ready", 32'(cfg_ready), 0);
        chk("oor_lane2", 32'(pat_out[23:16]), 'h10);
        enable = 1'b1;
        step();

        // accept coinciding with a due step
        cfg(0, 1, 0, 'h40);
        step();
        chk("div0_tick", 32'(tick[0]), 1);
        cfg(0, 1, 0, 'h33);
        chk("coll_seed", 32'(pat_out[7:0]), 'h33);
        chk("coll_tick", 32'(tick[0]), 0);
        step();
        chk("coll_next", 32'(pat_out[7:0]), 'h34);

        // mid-run reset with cfg_valid high
        rst = 1'b1;
        cfg(1, 1, 0, 'h77);
        chk("mrst_pat", 32'(pat_out), 0);
        chk("mrst_tick", 32'(tick), 0);
        chk("mrst_ready", 32'(cfg_ready), 0);
        rst = 1'b0;
        step();
        step();
        chk("mrst_idle", 32'(pat_out), 0);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            rst       = ($urandom % 100) == 0;
            enable    = ($urandom % 4) != 0;
            cfg_valid = ($urandom % 5) == 0;
            cfg_ch    = 2'($urandom % 4);
            cfg_mode  = 2'($urandom % 4);
            cfg_div   = DW'($urandom % 4);
            cfg_seed  = W'(($urandom % 4 == 0) ? 0 : $urandom);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
